// File: rtl/cnn_layer_accel_result_pkg.sv
// Shared definitions for the CNN layer accelerator result packer.
// Holds the lane/word geometry, the packer FSM state encoding, the
// packed output word layout and a helper that builds lane-valid masks.
package cnn_layer_accel_result_pkg;

  localparam int unsigned C_RESULT_WIDTH = 16;
  localparam int unsigned C_OUT_WIDTH    = 128;
  localparam int unsigned C_RES_PER_WORD = C_OUT_WIDTH / C_RESULT_WIDTH;
  localparam int unsigned C_LANE_IDX_W   = $clog2(C_RES_PER_WORD);

  typedef logic [C_LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_PACK,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [C_OUT_WIDTH-1:0]    data;
    logic [C_RES_PER_WORD-1:0] keep;
    logic                      last;
  } packed_word_t;

  // Ones in lanes 0..top_lane, zeros above.
  function automatic logic [C_RES_PER_WORD-1:0] keep_mask(input lane_idx_t top_lane);
    logic [C_RES_PER_WORD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < C_RES_PER_WORD; i++) begin
      m[i] = (i <= 32'(top_lane));
    end
    return m;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_pos_counter.sv
// Output position tracker for the result packer.
// Column advances fastest, then row, then depth. Each counter wraps at its
// configured size minus one and carries into the next.
// Ports:
//   clk_core, rst      : clock, synchronous active-low reset
//   clear              : zero all three positions (start of a job)
//   advance            : one result accepted, step to the next position
//   rows_cfg, cols_cfg : latched job dimensions used for wrapping
//   row, col, depth    : position of the next result to be accepted
module cnn_layer_accel_pos_counter (
  input  logic        clk_core,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  input  logic [9:0]  rows_cfg,
  input  logic [9:0]  cols_cfg,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic [31:0] depth
);

  logic [31:0] row_q, row_d;
  logic [31:0] col_q, col_d;
  logic [31:0] depth_q, depth_d;
  logic [31:0] col_last;
  logic [31:0] row_last;

  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    depth_d  = depth_q;
    col_last = {22'd0, cols_cfg} - 32'd1;
    row_last = {22'd0, rows_cfg} - 32'd1;
    if (clear) begin
      row_d   = '0;
      col_d   = '0;
      depth_d = '0;
    end else if (advance) begin
      if (col_q == col_last) begin
        col_d = '0;
        if (row_q == row_last) begin
          row_d   = '0;
          depth_d = depth_q + 32'd1;
        end else begin
          row_d = row_q + 32'd1;
        end
      end else begin
        col_d = col_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      depth_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      depth_q <= depth_d;
    end
  end

  assign row   = row_q;
  assign col   = col_q;
  assign depth = depth_q;

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Result packer: consumes 16-bit convolution results over a valid/accept
// handshake and packs eight of them per 128-bit word, lane 0 oldest.
// Counts results against rows*cols*kernels, flags the final (possibly
// partial) word with packed_last and tracks the output position.
// Ports:
//   clk_core, rst                 : clock, synchronous active-low reset
//   job_start / job_accept        : job request and same-cycle acknowledge
//   num_*_cfg                     : job dimensions, sampled with job_start
//   result_valid/accept/data      : incoming result stream
//   packed_valid/ready/data/keep/last : outgoing packed word stream
//   job_done                      : one-cycle pulse after the final word
//   output_row/col/depth          : position of the next result to accept
module cnn_layer_accel_result_packer
  import cnn_layer_accel_result_pkg::*;
(
  input  logic         clk_core,
  input  logic         rst,
  input  logic         job_start,
  output logic         job_accept,
  input  logic [9:0]   num_output_rows_cfg,
  input  logic [9:0]   num_output_cols_cfg,
  input  logic [6:0]   num_kernel_cfg,
  input  logic         result_valid,
  output logic         result_accept,
  input  logic [15:0]  result_data,
  output logic         packed_valid,
  input  logic         packed_ready,
  output logic [127:0] packed_data,
  output logic [7:0]   packed_keep,
  output logic         packed_last,
  output logic         job_done,
  output logic [31:0]  output_row,
  output logic [31:0]  output_col,
  output logic [31:0]  output_depth
);

  localparam lane_idx_t LAST_LANE = lane_idx_t'(C_RES_PER_WORD - 1);

  typedef logic [C_RES_PER_WORD-1:0][C_RESULT_WIDTH-1:0] lane_buf_t;

  state_e       state_q, state_d;
  logic [9:0]   rows_q, rows_d;
  logic [9:0]   cols_q, cols_d;
  logic [6:0]   kern_q, kern_d;
  logic [31:0]  total_q, total_d;
  logic [31:0]  count_q, count_d;
  lane_idx_t    lane_cnt_q, lane_cnt_d;
  lane_buf_t    lane_buf_q, lane_buf_d;
  packed_word_t word_q, word_d;
  logic         pv_q, pv_d;

  logic [31:0]  remaining;
  logic         completes;
  logic         accept;
  logic         take;
  logic         job_accept_c;
  logic         pos_clear;
  lane_buf_t    new_word;

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    kern_d       = kern_q;
    total_d      = total_q;
    count_d      = count_q;
    lane_cnt_d   = lane_cnt_q;
    lane_buf_d   = lane_buf_q;
    word_d       = word_q;
    pv_d         = pv_q && !packed_ready;
    accept       = 1'b0;
    take         = 1'b0;
    job_accept_c = 1'b0;
    pos_clear    = 1'b0;
    remaining    = total_q - count_q;
    completes    = (lane_cnt_q == LAST_LANE) || (remaining == 32'd1);
    // The completing result bypasses the lane buffer so the word is
    // registered on the same edge it is accepted.
    new_word             = lane_buf_q;
    new_word[lane_cnt_q] = result_data;

    unique case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          rows_d       = num_output_rows_cfg;
          cols_d       = num_output_cols_cfg;
          kern_d       = num_kernel_cfg;
          job_accept_c = 1'b1;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        total_d    = 32'(rows_q) * 32'(cols_q) * 32'(kern_q);
        count_d    = '0;
        lane_cnt_d = '0;
        lane_buf_d = '0;
        pos_clear  = 1'b1;
        state_d    = (total_d == 32'd0) ? ST_DONE : ST_PACK;
      end
      ST_PACK: begin
        // Hold off only the word-completing result while the output
        // register is still occupied and not being drained this cycle.
        accept = !(completes && pv_q && !packed_ready);
        take   = accept && result_valid;
        if (take) begin
          count_d = count_q + 32'd1;
          if (completes) begin
            word_d.data = new_word;
            word_d.keep = keep_mask(lane_cnt_q);
            word_d.last = (remaining == 32'd1);
            pv_d        = 1'b1;
            lane_buf_d  = '0;
            lane_cnt_d  = '0;
            if (remaining == 32'd1) state_d = ST_DRAIN;
          end else begin
            lane_buf_d[lane_cnt_q] = result_data;
            lane_cnt_d             = lane_cnt_q + lane_idx_t'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pv_q && packed_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      kern_q     <= '0;
      total_q    <= '0;
      count_q    <= '0;
      lane_cnt_q <= '0;
      lane_buf_q <= '0;
      word_q     <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      kern_q     <= kern_d;
      total_q    <= total_d;
      count_q    <= count_d;
      lane_cnt_q <= lane_cnt_d;
      lane_buf_q <= lane_buf_d;
      word_q     <= word_d;
      pv_q       <= pv_d;
    end
  end

  cnn_layer_accel_pos_counter u_pos (
    .clk_core (clk_core),
    .rst      (rst),
    .clear    (pos_clear),
    .advance  (take),
    .rows_cfg (rows_q),
    .cols_cfg (cols_q),
    .row      (output_row),
    .col      (output_col),
    .depth    (output_depth)
  );

  // Acknowledge is combinational from job_start; masked while reset is
  // asserted so every output reads zero during reset.
  assign job_accept    = job_accept_c && rst;
  assign result_accept = accept;
  assign packed_valid  = pv_q;
  assign packed_data   = word_q.data;
  assign packed_keep   = word_q.keep;
  assign packed_last   = word_q.last;
  assign job_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Self-checking bench for cnn_layer_accel_result_packer.
module tb_cnn_layer_accel_result_packer;

  logic         clk_core = 1'b0;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [9:0]   num_output_rows_cfg;
  logic [9:0]   num_output_cols_cfg;
  logic [6:0]   num_kernel_cfg;
  logic         result_valid;
  logic         result_accept;
  logic [15:0]  result_data;
  logic         packed_valid;
  logic         packed_ready;
  logic [127:0] packed_data;
  logic [7:0]   packed_keep;
  logic         packed_last;
  logic         job_done;
  logic [31:0]  output_row;
  logic [31:0]  output_col;
  logic [31:0]  output_depth;

  always #5 clk_core = ~clk_core;

  cnn_layer_accel_result_packer dut (
    .clk_core            (clk_core),
    .rst                 (rst),
    .job_start           (job_start),
    .job_accept          (job_accept),
    .num_output_rows_cfg (num_output_rows_cfg),
    .num_output_cols_cfg (num_output_cols_cfg),
    .num_kernel_cfg      (num_kernel_cfg),
    .result_valid        (result_valid),
    .result_accept       (result_accept),
    .result_data         (result_data),
    .packed_valid        (packed_valid),
    .packed_ready        (packed_ready),
    .packed_data         (packed_data),
    .packed_keep         (packed_keep),
    .packed_last         (packed_last),
    .job_done            (job_done),
    .output_row          (output_row),
    .output_col          (output_col),
    .output_depth        (output_depth)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   keep;
    logic         last;
  } exp_word_t;

  exp_word_t   exp_q[$];
  exp_word_t   mon_e;
  logic [15:0] stim_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          j_rows = 1;
  int          j_cols = 1;

  // Scoreboard: a word handshake seen at the falling edge completes on
  // the next rising edge; compare it against the oldest expected word.
  always @(negedge clk_core) begin
    if (rst === 1'b1 && packed_valid === 1'b1 && packed_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data=%h keep=%h last=%b, required no word",
                 packed_data, packed_keep, packed_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (packed_data !== mon_e.data || packed_keep !== mon_e.keep || packed_last !== mon_e.last) begin
          n_err++;
          $display("FAIL packed_word: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                   packed_data, packed_keep, packed_last, mon_e.data, mon_e.keep, mon_e.last);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Reference packing of stim_q into expected words.
  task automatic build_expected();
    exp_word_t w;
    int n;
    int lane;
    w = '0;
    n = stim_q.size();
    for (int i = 0; i < n; i++) begin
      lane = i % 8;
      w.data[lane*16 +: 16] = stim_q[i];
      w.keep[lane] = 1'b1;
      if (lane == 7 || i == n - 1) begin
        w.last = (i == n - 1);
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  // Ends in the CALC cycle (one cycle after the sampling edge).
  task automatic start_job(input int r, input int c, input int k);
    num_output_rows_cfg = 10'(r);
    num_output_cols_cfg = 10'(c);
    num_kernel_cfg      = 7'(k);
    job_start           = 1'b1;
    #1;
    n_cmp++;
    if (job_accept !== 1'b1) begin
      n_err++;
      $display("FAIL job_accept: got %b, required 1", job_accept);
    end
    tick();
    job_start = 1'b0;
    j_rows    = r;
    j_cols    = c;
  endtask

  // Offer stim_q[idx]; checks the reported position at the accepting edge.
  task automatic offer(input int idx);
    int waited;
    logic [95:0] exp_pos;
    result_valid = 1'b1;
    result_data  = stim_q[idx];
    #1;
    waited = 0;
    while (result_accept !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (result_accept !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: result %0d got accept=%b, required 1 within 20 cycles", idx, result_accept);
    end else begin
      exp_pos = {32'((idx / j_cols) % j_rows), 32'(idx % j_cols), 32'(idx / (j_rows * j_cols))};
      if ({output_row, output_col, output_depth} !== exp_pos) begin
        n_err++;
        $display("FAIL position: result %0d got r/c/d=%0d/%0d/%0d, required %0d/%0d/%0d", idx,
                 output_row, output_col, output_depth, exp_pos[95:64], exp_pos[63:32], exp_pos[31:0]);
      end
    end
    tick();
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (job_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({packed_valid, result_accept, job_accept, job_done, packed_data, packed_keep, packed_last,
         output_row, output_col, output_depth} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b acc=%b jacc=%b done=%b data=%h keep=%h last=%b pos=%0d/%0d/%0d, required all 0",
               packed_valid, result_accept, job_accept, job_done, packed_data, packed_keep, packed_last,
               output_row, output_col, output_depth);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'(i + 1));
    build_expected();
    start_job(2, 2, 2);
    for (int i = 0; i < 8; i++) offer(i);
    result_valid = 1'b0;
    n_cmp++;
    if (packed_valid !== 1'b1 || packed_last !== 1'b1 || packed_keep !== 8'hFF) begin
      n_err++;
      $display("FAIL full_word_out: got valid=%b last=%b keep=%h, required 1 1 ff", packed_valid, packed_last, packed_keep);
    end
    tick();
    n_cmp++;
    if (job_done !== 1'b1 || packed_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_word_done: got done=%b valid=%b, required 1 0", job_done, packed_valid);
    end
    tick();
    n_cmp++;
    if (job_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: got %b, required 0", job_done);
    end
    n_cmp++;
    if ({output_row, output_col, output_depth} !== {32'd0, 32'd0, 32'd2}) begin
      n_err++;
      $display("FAIL final_position: got %0d/%0d/%0d, required 0/0/2", output_row, output_col, output_depth);
    end
  endtask

  task automatic test_partial_word();
    bit seen;
    stim_q.delete();
    stim_q.push_back(16'h000A);
    stim_q.push_back(16'h000B);
    stim_q.push_back(16'h000C);
    build_expected();
    start_job(3, 1, 1);
    for (int i = 0; i < 3; i++) offer(i);
    result_valid = 1'b0;
    n_cmp++;
    if (packed_valid !== 1'b1 || packed_keep !== 8'h07 || packed_last !== 1'b1) begin
      n_err++;
      $display("FAIL partial_keep: got valid=%b keep=%h last=%b, required 1 07 1", packed_valid, packed_keep, packed_last);
    end
    wait_done(seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL partial_done: got no job_done, required pulse");
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit seen;
    exp_word_t w1;
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i + 1));
    build_expected();
    w1 = exp_q[0];
    start_job(4, 4, 1);
    for (int i = 0; i < 7; i++) offer(i);
    packed_ready = 1'b0;
    for (int i = 7; i < 15; i++) offer(i);
    result_valid = 1'b1;
    result_data  = stim_q[15];
    #1;
    n_cmp++;
    if (result_accept !== 1'b0) begin
      n_err++;
      $display("FAIL stall_accept: got %b, required 0", result_accept);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (packed_valid !== 1'b1 || packed_data !== w1.data || packed_keep !== w1.keep ||
          packed_last !== w1.last || result_accept !== 1'b0) begin
        n_err++;
        $display("FAIL held_word: cycle %0d got valid=%b data=%h keep=%h last=%b acc=%b, required 1 %h %h %b 0",
                 k, packed_valid, packed_data, packed_keep, packed_last, result_accept, w1.data, w1.keep, w1.last);
      end
    end
    packed_ready = 1'b1;
    offer(15);
    result_valid = 1'b0;
    wait_done(seen);
    n_cmp++;
    if (!seen || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL backpressure_done: got done_seen=%b pending_words=%0d, required 1 0", seen, exp_q.size());
    end
    tick();
  endtask

  task automatic test_zero_dim();
    start_job(2, 2, 0);
    n_cmp++;
    if (job_done !== 1'b0 || packed_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_calc: got done=%b valid=%b, required 0 0", job_done, packed_valid);
    end
    tick();
    n_cmp++;
    if (job_done !== 1'b1 || packed_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b valid=%b, required 1 0", job_done, packed_valid);
    end
    tick();
    n_cmp++;
    if (job_done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done_width: got %b, required 0", job_done);
    end
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'h1000 + 16'(i));
    start_job(2, 2, 2);
    for (int i = 0; i < 5; i++) offer(i);
    result_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({packed_valid, result_accept, job_accept, job_done, packed_data, packed_keep, packed_last,
         output_row, output_col, output_depth} !== '0) begin
      n_err++;
      $display("FAIL midjob_reset: got valid=%b acc=%b done=%b keep=%h pos=%0d/%0d/%0d, required all 0",
               packed_valid, result_accept, job_done, packed_keep, output_row, output_col, output_depth);
    end
    rst = 1'b1;
    tick();
    stim_q.delete();
    stim_q.push_back(16'h0055);
    build_expected();
    start_job(1, 1, 1);
    offer(0);
    result_valid = 1'b0;
    n_cmp++;
    if (packed_valid !== 1'b1 || packed_keep !== 8'h01 || packed_data !== 128'h55) begin
      n_err++;
      $display("FAIL fresh_word: got valid=%b keep=%h data=%h, required 1 01 %h", packed_valid, packed_keep, packed_data, 128'h55);
    end
    wait_done(seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL fresh_done: got no job_done, required pulse");
    end
    tick();
  endtask

  task automatic test_job_start_ignored();
    bit seen;
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(16'h0100 + 16'(i));
    build_expected();
    start_job(3, 2, 2);
    for (int i = 0; i < 4; i++) offer(i);
    num_output_rows_cfg = 10'd1;
    num_output_cols_cfg = 10'd1;
    num_kernel_cfg      = 7'd1;
    job_start           = 1'b1;
    #1;
    n_cmp++;
    if (job_accept !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_pack: got job_accept=%b, required 0", job_accept);
    end
    offer(4);
    job_start = 1'b0;
    for (int i = 5; i < 12; i++) offer(i);
    result_valid = 1'b0;
    wait_done(seen);
    n_cmp++;
    if (!seen || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ignored_done: got done_seen=%b pending_words=%0d, required 1 0", seen, exp_q.size());
    end
    n_cmp++;
    if ({output_row, output_col, output_depth} !== {32'd0, 32'd0, 32'd2}) begin
      n_err++;
      $display("FAIL ignored_final_pos: got %0d/%0d/%0d, required 0/0/2", output_row, output_col, output_depth);
    end
    tick();
  endtask

  initial begin
    rst                 = 1'b0;
    job_start           = 1'b0;
    num_output_rows_cfg = '0;
    num_output_cols_cfg = '0;
    num_kernel_cfg      = '0;
    result_valid        = 1'b0;
    result_data         = '0;
    packed_ready        = 1'b1;

    test_reset();
    test_full_word();
    test_partial_word();
    test_backpressure();
    test_zero_dim();
    test_reset_mid_job();
    test_job_start_ignored();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d pending words, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
